// File: rtl/descaler.sv
// Serial de-normalizer: applies the net inverse of the scaler's shifts to a
// signed Q-format value one bit per clock, saturating on left-shift overflow.
module descaler #(
    parameter int W  = 16,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [W-1:0]  y_i,
    input  logic [SW-1:0] shift_l_i,
    input  logic [SW-1:0] shift_r_i,
    output logic [W-1:0]  y_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          ovf_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

    state_t              state_q;
    logic signed [W-1:0] acc_q;
    logic [SW:0]         cnt_q;
    logic                dir_left_q;
    logic                ovf_q;

    logic signed [SW:0]  net_d;
    logic [SW:0]         mag_d;
    logic signed [W-1:0] acc_step_d;
    logic                ovf_step_d;

    // Net shift is shift_r - shift_l; positive means undo by shifting left.
    assign net_d = $signed({1'b0, shift_r_i}) - $signed({1'b0, shift_l_i});
    assign mag_d = net_d[SW] ? (~net_d + 1'b1) : net_d;

    always_comb begin
        acc_step_d = acc_q;
        ovf_step_d = ovf_q;
        if (dir_left_q) begin
            // After saturating, the accumulator is frozen but the count keeps running.
            if (!ovf_q) begin
                if (acc_q[W-1] != acc_q[W-2]) begin
                    acc_step_d = acc_q[W-1] ? SAT_NEG : SAT_POS;
                    ovf_step_d = 1'b1;
                end else begin
                    acc_step_d = acc_q <<< 1;
                end
            end
        end else begin
            acc_step_d = acc_q >>> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            dir_left_q <= 1'b0;
            ovf_q      <= 1'b0;
            y_o        <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            ovf_o      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        acc_q      <= y_i;
                        cnt_q      <= mag_d;
                        dir_left_q <= ~net_d[SW];
                        ovf_q      <= 1'b0;
                        busy_o     <= 1'b1;
                        state_q    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (cnt_q != '0) begin
                        acc_q <= acc_step_d;
                        ovf_q <= ovf_step_d;
                        cnt_q <= cnt_q - (SW+1)'(1);
                    end else begin
                        y_o     <= acc_q;
                        ovf_o   <= ovf_q;
                        done_o  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_descaler.sv
// Directed self-checking bench for descaler: shift directions, saturation,
// net-zero pass-through, start-while-busy and reset mid-operation.
module tb_descaler;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [15:0] y_i;
    logic [2:0]  shift_l_i;
    logic [2:0]  shift_r_i;
    logic [15:0] y_o;
    logic        busy_o;
    logic        done_o;
    logic        ovf_o;

    int checks;
    int errors;

    descaler #(.W(16), .SW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .y_i       (y_i),
        .shift_l_i (shift_l_i),
        .shift_r_i (shift_r_i),
        .y_o       (y_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .ovf_o     (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge; start is sampled at the next edge (edge k).
    task automatic do_op(input logic [15:0] y, input logic [2:0] sl, input logic [2:0] sr,
                         input logic [15:0] exp_y, input logic exp_ovf, input int lat);
        int e;
        bit seen;
        y_i       = y;
        shift_l_i = sl;
        shift_r_i = sr;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        y_i       = 16'hDEAD;
        shift_l_i = 3'd5;
        shift_r_i = 3'd2;
        check("busy_at_k", busy_o, 1);
        e    = 0;
        seen = 0;
        while (!seen && e < 40) begin
            tick();
            e++;
            if (done_o) seen = 1;
            else check("busy_before_done", busy_o, 1);
        end
        check("done_seen", seen, 1);
        check("done_edge", e, lat);
        check("y_o", y_o, exp_y);
        check("ovf_o", ovf_o, exp_ovf);
        check("busy_at_done", busy_o, 1);
        tick();
        check("done_one_cycle", done_o, 0);
        check("busy_after", busy_o, 0);
        check("y_o_held", y_o, exp_y);
        $display("op y=0x%04h l=%0d r=%0d -> y_o=0x%04h ovf=%0b done@k+%0d", y, sl, sr, y_o, ovf_o, e);
    endtask

    typedef struct {
        logic [15:0] y;
        logic [2:0]  sl;
        logic [2:0]  sr;
        logic [15:0] ey;
        logic        eovf;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int e;
        int done_cnt;
        int done_edge;
        checks = 0;
        errors = 0;

        vecs[0] = '{16'h2000, 3'd0, 3'd1, 16'h4000, 1'b0, 2};
        vecs[1] = '{16'h6000, 3'd3, 3'd0, 16'h0C00, 1'b0, 4};
        vecs[2] = '{16'hC000, 3'd1, 3'd0, 16'hE000, 1'b0, 2};
        vecs[3] = '{16'h5000, 3'd0, 3'd2, 16'h7FFF, 1'b1, 3};
        vecs[4] = '{16'hA000, 3'd0, 3'd1, 16'h8000, 1'b1, 2};
        vecs[5] = '{16'h1234, 3'd3, 3'd3, 16'h1234, 1'b0, 1};
        vecs[6] = '{16'h0001, 3'd0, 3'd7, 16'h0080, 1'b0, 8};
        vecs[7] = '{16'h8000, 3'd7, 3'd0, 16'hFF00, 1'b0, 8};
        vecs[8] = '{16'h0800, 3'd2, 3'd5, 16'h4000, 1'b0, 4};

        rst       = 1'b1;
        start_i   = 1'b1;
        y_i       = 16'h1111;
        shift_l_i = 3'd0;
        shift_r_i = 3'd0;
        repeat (3) tick();
        check("rst_y_o", y_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_ovf", ovf_o, 0);
        start_i = 1'b0;
        rst     = 1'b0;
        tick();

        for (int i = 0; i < 9; i++)
            do_op(vecs[i].y, vecs[i].sl, vecs[i].sr, vecs[i].ey, vecs[i].eovf, vecs[i].lat);

        // Start while busy: the second request must be ignored.
        y_i       = 16'h0100;
        shift_l_i = 3'd0;
        shift_r_i = 3'd7;
        start_i   = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        y_i       = 16'h7FFF;
        shift_r_i = 3'd0;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        e         = 2;
        done_cnt  = 0;
        done_edge = -1;
        while (e < 20) begin
            tick();
            e++;
            if (done_o) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_edge = e;
                    check("busy_start_y_o", y_o, 16'h7FFF);
                    check("busy_start_ovf", ovf_o, 1);
                end
            end
        end
        check("busy_start_done_count", done_cnt, 1);
        check("busy_start_done_edge", done_edge, 8);
        check("busy_start_idle", busy_o, 0);
        $display("op busy-start y=0x0100 r=7 -> y_o=0x%04h ovf=%0b pulses=%0d", y_o, ovf_o, done_cnt);

        // Reset in the middle of a long right shift.
        y_i       = 16'h7FFF;
        shift_l_i = 3'd6;
        shift_r_i = 3'd0;
        start_i   = 1'b1;
        tick();
        start_i = 1'b0;
        check("midrst_busy_k", busy_o, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("midrst_no_done", done_o, 0);
        end
        rst = 1'b1;
        start_i = 1'b1;
        tick();
        rst = 1'b0;
        start_i = 1'b0;
        check("midrst_y_o", y_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_done", done_o, 0);
        check("midrst_ovf", ovf_o, 0);
        tick();
        check("midrst_still_idle", busy_o, 0);
        check("midrst_no_late_done", done_o, 0);
        $display("op reset mid-op -> y_o=0x%04h busy=%0b", y_o, busy_o);
        do_op(16'h7FFF, 3'd6, 3'd0, 16'h01FF, 1'b0, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/descaler.md
# descaler

Sequential de-normalizer that undoes the range scaling applied ahead of the approximation datapath. The scaler moves an operand into the Q2.14 window [0.75, 1.5] and reports how many single-bit left and right shifts it applied. This block takes the approximated Q2.14 result plus those two shift counts and applies the net inverse shift, one bit per clock. The result is saturated to the signed W-bit range, and completion is signalled with a one-cycle done pulse.

## Interface
- W, 16, data width in bits; signed two's complement, Q2.14 for W=16 (0x4000 = 1.0).
- SW, 3, width of the shift-count inputs.
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- start_i  input  1  request; sampled only in IDLE.
- y_i  input  W  signed value to de-scale; captured on the accepted start edge.
- shift_l_i  input  SW  left shifts applied by the scaler; undone here by right shifts.
- shift_r_i  input  SW  right shifts applied by the scaler; undone here by left shifts.
- y_o  output  W  signed de-scaled result; registered, held until the next accepted start.
- busy_o  output  1  high in SHIFT and DONE.
- done_o  output  1  one-cycle pulse marking y_o and ovf_o valid.
- ovf_o  output  1  saturation occurred in the current or last operation; held with y_o.

## Operation
- Net shift: n = shift_r_i − shift_l_i, computed as a signed (SW+1)-bit value, range −7..+7 for SW=3. Both inputs nonzero is legal; only n matters.
- n > 0: arithmetic left shift by n. n < 0: arithmetic right shift by |n|, sign-extending and truncating toward −∞. n = 0: value passes through unchanged.
- States and transitions:
  - IDLE: on start_i, load acc ← y_i, cnt ← |n|, dir ← sign of n, clear ovf; go to SHIFT.
  - SHIFT, cnt ≠ 0: shift acc one bit in direction dir; cnt ← cnt − 1.
  - SHIFT, cnt = 0: y_o ← acc, done_o ← 1; go to DONE.
  - DONE: done_o ← 0; go to IDLE.
- Left-shift saturation: if acc[W−1] ≠ acc[W−2] before a left step, acc ← 0x7FFF when acc is positive or 0x8000 when negative (W=16), and ovf is set.
  - Once ovf is set, acc is held for the remaining steps. The counter still runs, so latency is unchanged.
- Right shifts never set ovf.
- start_i while busy_o = 1 is ignored. No queueing; the input is not re-sampled.
- y_i, shift_l_i and shift_r_i are don't-care except on the accepted start edge.

## Timing
- Reset values: y_o = 0, done_o = 0, busy_o = 0, ovf_o = 0, state = IDLE, acc = 0, cnt = 0.
- start_i is sampled at edge k:
  - busy_o is high from edge k to edge k+|n|+2.
  - done_o, y_o and ovf_o are updated at edge k+|n|+1. done_o stays high for exactly one cycle.
  - Total latency is |n|+2 cycles edge-to-idle. For n = 0, done_o rises at edge k+1.
- Earliest next start is the cycle after DONE, sampled at edge k+|n|+2. Back-to-back throughput is one operation per |n|+2 cycles.
- Reset mid-operation (SHIFT or DONE):
  - Return to IDLE with all outputs at reset values on that edge.
  - No done_o pulse for the aborted operation.
- rst and start_i high on the same edge: rst wins.

## Test plan
- y_i=0x2000, shift_r_i=1, shift_l_i=0, start at edge k -> done_o pulse at edge k+2; y_o=0x4000, ovf_o=0; busy_o low after edge k+3.
- y_i=0x6000, shift_l_i=3, shift_r_i=0 -> y_o=0x0C00 after 5-cycle latency. Also y_i=0xC000, shift_l_i=1 -> y_o=0xE000 (sign preserved).
- Saturation:
  - y_i=0x5000, shift_r_i=2 -> y_o=0x7FFF, ovf_o=1, done_o at edge k+3.
  - y_i=0xA000, shift_r_i=1 -> y_o=0x8000, ovf_o=1.
- Net zero: y_i=0x1234, shift_r_i=3, shift_l_i=3 -> y_o=0x1234, done_o at edge k+1, ovf_o=0.
- Start while busy: start y_i=0x0100, shift_r_i=7; pulse start_i with y_i=0x7FFF two cycles later -> second request ignored; y_o=0x7FFF via saturation of the first operation (0x0100<<7 = 0x8000 overflows), ovf_o=1, exactly one done_o pulse.
- Reset mid-op: start with shift_l_i=6, assert rst at edge k+3 -> all outputs 0 at edge k+3, no done_o. A new start at edge k+5 completes normally.
